// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file writeback control path.
package rf_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One buffered multi-cycle result waiting for the write port.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage : rf_ctrl_pkg

// File: rtl/wb_fifo.sv
// Small FIFO holding multi-cycle results until the shared write port is free.
// Pointers wrap modulo DEPTH; the occupancy count tells full from empty.
module wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Advance a pointer, wrapping after the last slot.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage write; only the slot under the write pointer changes.
  // NOTE: the storage array has no reset -- a zero count already makes every
  // slot invalid, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule : wb_fifo

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU writeback
// (priority, never stalls) and buffered multi-cycle results, and tracks
// outstanding multi-cycle destinations to stall decode on RAW/WAW hazards.
module regfile_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = rf_ctrl_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  // ALU writeback
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  // Multi-cycle issue from decode
  input  logic                  mc_issue,
  input  logic [REG_ADDR_W-1:0] mc_issue_rd,
  output logic                  mc_issue_ready,
  // Multi-cycle result
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  mc_ready,
  // Decode hazard check
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  output logic                  stall,
  // Register file write port
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(DEPTH);

  // Architectural state
  logic [NUM_REGS-1:0]   r_busy;
  logic [CNT_W-1:0]      r_outstanding;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;

  // Queue interface
  logic      w_full;
  logic      w_empty;
  wb_entry_t w_head;
  wb_entry_t w_push_entry;

  // Per-cycle events
  logic                w_issue_accept;
  logic                w_mc_accept;
  logic                w_push;
  logic                w_consume;
  logic                w_alu_wr;
  logic                w_pop;
  logic [NUM_REGS-1:0] w_busy_next;

  // Credit check uses only the registered count: a retiring entry this cycle
  // does not free a slot until the next one.
  assign mc_issue_ready = (r_outstanding < MAX_OUT);
  assign mc_ready       = !w_full;

  assign w_issue_accept = mc_issue && mc_issue_ready;
  assign w_mc_accept    = mc_valid && mc_ready;
  // Results for x0 retire their credit immediately and never reach the port.
  assign w_push         = w_mc_accept && (mc_rd != '0);
  assign w_consume      = w_mc_accept && (mc_rd == '0);
  // ALU writes to x0 are no-ops and must not block the queue head.
  assign w_alu_wr       = alu_valid && (alu_rd != '0);
  assign w_pop          = !w_alu_wr && !w_empty;

  assign w_push_entry = '{rd: mc_rd, data: mc_data};

  assign stall = r_busy[dec_rs1] | r_busy[dec_rs2] | r_busy[dec_rd];

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_entry(w_push_entry),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  // Next scoreboard: clear on retire first, then set on issue so a same-cycle
  // issue to the retiring register keeps it busy.
  // NOTE: combinational blocks assign a default to every output first so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) begin
      w_busy_next[w_head.rd] = 1'b0;
    end
    if (w_issue_accept && (mc_issue_rd != '0)) begin
      w_busy_next[mc_issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard and outstanding-op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy        <= '0;
      r_outstanding <= '0;
    end else begin
      r_busy        <= w_busy_next;
      r_outstanding <= r_outstanding
                       + CNT_W'(w_issue_accept)
                       - CNT_W'(w_pop)
                       - CNT_W'(w_consume);
    end
  end

  // Registered write port: ALU first, else queue head, else idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_alu_wr) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= alu_rd;
      r_rf_wdata <= alu_data;
    end else if (w_pop) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_head.rd;
      r_rf_wdata <= w_head.data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mc_issue;
  logic [4:0]      mc_issue_rd;
  logic            mc_issue_ready;
  logic            mc_valid;
  logic [4:0]      mc_rd;
  logic [XLEN-1:0] mc_data;
  logic            mc_ready;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic            stall;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  regfile_wb_arbiter #(
    .DEPTH(DEPTH),
    .XLEN (XLEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mc_issue      (mc_issue),
    .mc_issue_rd   (mc_issue_rd),
    .mc_issue_ready(mc_issue_ready),
    .mc_valid      (mc_valid),
    .mc_rd         (mc_rd),
    .mc_data       (mc_data),
    .mc_ready      (mc_ready),
    .dec_rs1       (dec_rs1),
    .dec_rs2       (dec_rs2),
    .dec_rd        (dec_rd),
    .stall         (stall),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of pending results, busy flags, credit count, and
  // the list of issued ops whose results the multi-cycle unit still owes.
  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t       m_q[$];
  bit         m_busy[32];
  int         m_out;
  logic [4:0] pend[$];

  int checks   = 0;
  int failures = 0;

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    mc_issue    = 1'b0;
    mc_issue_rd = '0;
    mc_valid    = 1'b0;
    mc_rd       = '0;
    mc_data     = '0;
  endtask

  task automatic model_reset();
    m_q.delete();
    pend.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_out = 0;
  endtask

  // One clock: check combinational outputs against the model, apply the
  // spec's per-edge rules to the model, advance, then check the write port.
  task automatic tick();
    ent_t       h;
    int         out_pre;
    int         qsz_pre;
    bit         e_we;
    logic [4:0] e_addr;
    logic [XLEN-1:0] e_data;
    bit         e_bit;
    #1;
    if (!rst) begin
      e_bit = (m_q.size() < DEPTH);
      checks++;
      if (mc_ready !== e_bit) begin
        failures++;
        $display("FAIL mc_ready t=%0t: got %b want %b", $time, mc_ready, e_bit);
      end
      e_bit = (m_out < DEPTH);
      checks++;
      if (mc_issue_ready !== e_bit) begin
        failures++;
        $display("FAIL mc_issue_ready t=%0t: got %b want %b", $time, mc_issue_ready, e_bit);
      end
      e_bit = m_busy[dec_rs1] | m_busy[dec_rs2] | m_busy[dec_rd];
      checks++;
      if (stall !== e_bit) begin
        failures++;
        $display("FAIL stall t=%0t rs1=%0d rs2=%0d rd=%0d: got %b want %b",
                 $time, dec_rs1, dec_rs2, dec_rd, stall, e_bit);
      end
    end

    e_we   = 1'b0;
    e_addr = '0;
    e_data = '0;
    if (rst) begin
      model_reset();
    end else begin
      out_pre = m_out;
      qsz_pre = m_q.size();
      if (alu_valid && alu_rd != 0) begin
        e_we = 1'b1; e_addr = alu_rd; e_data = alu_data;
      end else if (qsz_pre > 0) begin
        h = m_q.pop_front();
        e_we = 1'b1; e_addr = h.rd; e_data = h.data;
        m_busy[h.rd] = 1'b0;
        m_out--;
      end
      if (mc_valid && qsz_pre < DEPTH) begin
        if (pend.size() > 0) void'(pend.pop_front());
        if (mc_rd != 0) m_q.push_back('{rd: mc_rd, data: mc_data});
        else            m_out--;
      end
      if (mc_issue && out_pre < DEPTH) begin
        m_out++;
        pend.push_back(mc_issue_rd);
        if (mc_issue_rd != 0) m_busy[mc_issue_rd] = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    checks++;
    if (rf_we !== e_we) begin
      failures++;
      $display("FAIL rf_we t=%0t: got %b want %b", $time, rf_we, e_we);
    end
    if (e_we || rst) begin
      checks++;
      if (rf_waddr !== e_addr || rf_wdata !== e_data) begin
        failures++;
        $display("FAIL rf_write t=%0t: got x%0d=%h want x%0d=%h",
                 $time, rf_waddr, rf_wdata, e_addr, e_data);
      end
    end
  endtask

  // Return every owed result and let the queue empty, within a cycle budget.
  task automatic drain();
    int budget;
    budget = 60;
    while ((m_out > 0) && (budget > 0)) begin
      idle_inputs();
      if (pend.size() > 0 && m_q.size() < DEPTH) begin
        mc_valid = 1'b1;
        mc_rd    = pend[0];
        mc_data  = $urandom;
      end
      tick();
      budget--;
    end
    idle_inputs();
    tick();
    checks++;
    if (budget == 0 || mc_issue_ready !== 1'b1 || mc_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain: budget_left=%0d issue_ready=%b mc_ready=%b want issue_ready=1 mc_ready=1",
               budget, mc_issue_ready, mc_ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    dec_rs1 = 5'd3; dec_rs2 = 5'd17; dec_rd = 5'd31;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0) begin
      failures++;
      $display("FAIL reset_wport: got we=%b x%0d=%h want we=0 x0=0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (mc_ready !== 1'b1 || mc_issue_ready !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got mc_ready=%b issue_ready=%b stall=%b want 1 1 0",
               mc_ready, mc_issue_ready, stall);
    end
    rst = 1'b0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h0000_1234) begin
      failures++;
      $display("FAIL alu_write: got we=%b x%0d=%h want we=1 x5=00001234", rf_we, rf_waddr, rf_wdata);
    end
    alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL alu_x0: got we=%b want 0", rf_we);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_issue_retire();
    mc_issue = 1'b1; mc_issue_rd = 5'd10; dec_rs1 = 5'd10;
    tick();
    mc_issue = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL retire_stall_wait%0d: got %b want 1", i, stall);
      end
      tick();
    end
    mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'h0000_00AA;
    tick();
    mc_valid = 1'b0;
    checks++;
    if (stall !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL retire_pushed: got stall=%b we=%b want stall=1 we=0", stall, rf_we);
    end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h0000_00AA || stall !== 1'b0) begin
      failures++;
      $display("FAIL retire_write: got we=%b x%0d=%h stall=%b want we=1 x10=000000aa stall=0",
               rf_we, rf_waddr, rf_wdata, stall);
    end
    dec_rs1 = '0;
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    mc_issue = 1'b1; mc_issue_rd = 5'd3;
    tick();
    idle_inputs();
    mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'h3333_0003;
    tick();
    idle_inputs();
    dec_rs2   = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      alu_data = $urandom;
      tick();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || stall !== 1'b1) begin
        failures++;
        $display("FAIL contention_alu%0d: got we=%b waddr=%0d stall=%b want we=1 waddr=7 stall=1",
                 i, rf_we, rf_waddr, stall);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3333_0003 || stall !== 1'b0) begin
      failures++;
      $display("FAIL contention_mc: got we=%b x%0d=%h stall=%b want we=1 x3=33330003 stall=0",
               rf_we, rf_waddr, rf_wdata, stall);
    end
    dec_rs2 = '0;
    tick();
  endtask

  task automatic test_credit_limit();
    mc_issue = 1'b1; mc_issue_rd = 5'd1;
    tick();
    mc_issue_rd = 5'd2;
    tick();
    mc_issue = 1'b0;
    checks++;
    if (mc_issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL credit_full: got issue_ready=%b want 0", mc_issue_ready);
    end
    mc_issue = 1'b1; mc_issue_rd = 5'd6; dec_rd = 5'd6;
    tick();
    mc_issue = 1'b0;
    checks++;
    if (stall !== 1'b0 || mc_issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL credit_ignored: got stall=%b issue_ready=%b want 0 0", stall, mc_issue_ready);
    end
    dec_rd = '0;
    mc_valid = 1'b1; mc_rd = 5'd1; mc_data = 32'h0101_0101;
    tick();
    mc_valid = 1'b0;
    checks++;
    if (mc_issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL credit_queued: got issue_ready=%b want 0", mc_issue_ready);
    end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || mc_issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL credit_return: got we=%b waddr=%0d issue_ready=%b want 1 1 1",
               rf_we, rf_waddr, mc_issue_ready);
    end
    drain();
  endtask

  task automatic test_same_cycle();
    mc_issue = 1'b1; mc_issue_rd = 5'd4;
    tick();
    idle_inputs();
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h4444_0004;
    tick();
    idle_inputs();
    mc_issue = 1'b1; mc_issue_rd = 5'd4; dec_rd = 5'd4;
    tick();
    mc_issue = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || stall !== 1'b1 || mc_issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle: got we=%b waddr=%0d stall=%b issue_ready=%b want 1 4 1 1",
               rf_we, rf_waddr, stall, mc_issue_ready);
    end
    mc_issue = 1'b1; mc_issue_rd = 5'd9;
    tick();
    mc_issue = 1'b0;
    checks++;
    if (mc_issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_count: got issue_ready=%b want 0", mc_issue_ready);
    end
    dec_rd = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    mc_issue = 1'b1; mc_issue_rd = 5'd11;
    tick();
    mc_issue_rd = 5'd12;
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_1111;
    mc_valid = 1'b1; mc_rd = 5'd11; mc_data = 32'hB0B0_0011;
    tick();
    mc_rd = 5'd12; mc_data = 32'hB0B0_0012;
    tick();
    mc_valid = 1'b0;
    checks++;
    if (mc_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_full: got mc_ready=%b want 0", mc_ready);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0) begin
      failures++;
      $display("FAIL reset_mid_wport: got we=%b x%0d=%h want we=0 x0=0", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || mc_ready !== 1'b1 || mc_issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_after: got we=%b mc_ready=%b issue_ready=%b want 0 1 1",
               rf_we, mc_ready, mc_issue_ready);
    end
    for (int i = 0; i < 32; i++) begin
      dec_rs1 = 5'(i); dec_rs2 = 5'(i); dec_rd = 5'(i);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_stall x%0d: got %b want 0", i, stall);
      end
    end
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      rst         = ($urandom_range(0, 99) == 0);
      alu_valid   = $urandom_range(0, 1);
      alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_data    = $urandom;
      mc_issue    = ($urandom_range(0, 9) < 4);
      mc_issue_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      if (pend.size() > 0 && m_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        mc_valid = 1'b1;
        mc_rd    = pend[0];
        mc_data  = $urandom;
      end
      dec_rs1 = 5'($urandom);
      dec_rs2 = 5'($urandom);
      dec_rd  = 5'($urandom);
      tick();
    end
    rst = 1'b0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_alu_only();
    test_issue_retire();
    test_contention();
    test_credit_limit();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port between two sources:
  - ALU writeback, which has priority and never stalls.
  - A multi-cycle unit (load/mul-div), whose results are buffered in a small queue.
- Keeps a per-register busy scoreboard of outstanding multi-cycle destinations and raises a decode stall on RAW/WAW hazards.
- Sits between the execute/writeback stage and the register file, and drives its write_enable/write_address/write_data.

## Interface
- DEPTH, 2, result-queue entries; also the maximum number of outstanding multi-cycle ops.
- XLEN, 32, data width.

Clock and reset: one clock, `clk`. Reset is `rst`, synchronous and active-high.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- mc_issue  in  1  decode issues a multi-cycle op this cycle.
- mc_issue_rd  in  5  its destination.
- mc_issue_ready  out  1  issue may be accepted.
- mc_valid  in  1  multi-cycle unit result valid.
- mc_rd  in  5  result destination.
- mc_data  in  XLEN  result data.
- mc_ready  out  1  queue can accept a result.
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage operand/destination addresses.
- stall  out  1  decode must hold.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  XLEN  register file write data.

## Operation
- **State:**
  - busy[31:0] scoreboard; bit 0 is always 0.
  - Result queue of DEPTH entries {rd, data}.
  - Outstanding counter, 0..DEPTH.
- **Issue:**
  - Accepted when mc_issue && mc_issue_ready.
  - On accept: outstanding increments, and busy[mc_issue_rd] sets if rd≠0.
  - mc_issue while not ready is ignored.
- **mc_issue_ready:** outstanding < DEPTH, using the registered count only; no same-cycle credit from a retiring entry.
- **Result accept:**
  - Accepted when mc_valid && mc_ready, with mc_ready = queue not full.
  - rd≠0: the result is pushed.
  - rd=0: the result is consumed, outstanding decrements, nothing is pushed.
  - mc_valid while full is ignored (protocol error).
- **Arbitration, each posedge:**
  - alu_valid && alu_rd≠0: the ALU drives the write port. The queue head waits.
  - Otherwise, queue nonempty: the head is popped to the write port, busy[head.rd] clears, and outstanding decrements.
  - Otherwise: rf_we ← 0.
  - alu_valid with alu_rd=0 is a no-op and does not block the queue.
- **stall:** combinational; high when busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd].
- **Simultaneous events:**
  - Pop clearing busy[r] in the same cycle as an issue to r: the bit ends set (issue wins).
  - Push and pop in the same cycle with the queue full: legal. The pop frees the slot, but mc_ready still reflects the pre-edge full state.
  - Outstanding decrement and increment in the same cycle: net unchanged.
- **Reset:**
  - Clears busy, empties the queue, and zeroes outstanding.
  - rf_we=0, rf_waddr=0, rf_wdata=0, mc_ready=1, mc_issue_ready=1, stall=0.
  - Reset mid-operation discards queued results without writing them.

## Timing
- rf_we, rf_waddr and rf_wdata are registered.
  - The register file captures them at the negedge of the cycle in which they are presented.
- ALU path: alu_valid sampled at edge N → rf_we high during cycle N+1.
- Multi-cycle path:
  - Result pushed at edge N → earliest rf_we during cycle N+2.
  - Each cycle of ALU writes delays it by one cycle.
- Busy clears at the pop edge, so stall drops in the same cycle rf_we writes that register.
  - The negedge write then makes the new value visible to the combinational read in decode.
- Queue order is FIFO; results retire in arrival order.

## Structure
- Package rf_ctrl_pkg:
  - XLEN, REG_ADDR_W=5, NUM_REGS=32.
  - typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data;}.
- Sub-module wb_fifo:
  - Parameterised DEPTH, entries of wb_entry_t.
  - Ports: push, pop, full, empty, head.
  - Pointers wrap modulo DEPTH; the count distinguishes full from empty.
- Scoreboard, counter and arbitration logic stay in regfile_wb_arbiter.

## Test plan
- ALU only:
  - Stimulus: alu_valid, rd=5, data=0x1234 at edge 1.
  - Response: rf_we=1, waddr=5, wdata=0x1234 during cycle 2.
  - Stimulus: alu_rd=0.
  - Response: rf_we stays 0.
- Issue/retire:
  - Stimulus: issue rd=10; result 0xAA for rd=10 three cycles later.
  - Response: stall high while dec_rs1=10 until the cycle rf_we writes 0xAA to x10, then low.
- Contention:
  - Stimulus: mc result for rd=3 queued; alu_valid held for 3 cycles to rd=7.
  - Response: three ALU writes, then x3 written in the 4th write cycle. busy[3] stays set until then.
- Credit limit (DEPTH=2):
  - Stimulus: two issues accepted, then a third issue.
  - Response: mc_issue_ready=0 after the two issues, and the third issue is ignored.
  - Response: mc_issue_ready returns to 1 in the cycle after the first pop.
- Same-cycle issue/clear:
  - Stimulus: pop of rd=4 coincides with a new issue to rd=4.
  - Response: busy[4] remains 1, and outstanding is unchanged.
- Reset mid-operation:
  - Stimulus: two queued results, then rst for 1 cycle.
  - Response: no writes occur, all outputs take their reset values, and stall=0 for every dec address.
